// File: rtl/pulse_train_controller.sv
// pulse_train_controller
// Issues finite bursts of one-cycle pulses. Each command carries a period P
// (pulse spacing of P+1 enabled cycles) and a count C (number of pulses).
// A running burst ends on its last pulse (done) or on abort (aborted).
//
// Command handshake: a command transfers on any rising edge where
// cmd_valid_i && cmd_ready_o. The source holds cmd_period_i/cmd_count_i
// stable while cmd_valid_i is high and not yet accepted. cmd_ready_o is
// combinational and is high only in IDLE with abort_i low, so an abort in
// IDLE also blocks acceptance for that cycle.
module pulse_train_controller #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [PW-1:0] cmd_period_i,
    input  logic [CW-1:0] cmd_count_i,
    input  logic          abort_i,
    output logic          pulse_o,
    output logic          done_o,
    output logic          aborted_o,
    output logic          busy_o,
    output logic [CW-1:0] remaining_o,
    output logic          state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [PW-1:0] period_q;
    logic [PW-1:0] counter_q;
    logic [CW-1:0] remaining_q;
    logic          pulse_q;
    logic          done_q;
    logic          aborted_q;
    logic          busy_q;

    // Next-value helpers. counter_d is only used while counter_q < period_q,
    // and remaining_d only while remaining_q >= 1, so neither wraps.
    logic [PW-1:0] counter_d;
    logic [CW-1:0] remaining_d;
    logic          period_end;
    logic          last_pulse;
    logic          accept;

    assign counter_d   = counter_q + PW'(1);
    assign remaining_d = remaining_q - CW'(1);
    assign period_end  = (counter_q == period_q);
    assign last_pulse  = (remaining_q == CW'(1));
    assign accept      = cmd_valid_i && cmd_ready_o;

    // Ready is the only combinational output: IDLE and no abort this cycle.
    assign cmd_ready_o = (state_q == ST_IDLE) && !abort_i;

    // Control FSM; every status output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            counter_q   <= '0;
            remaining_q <= '0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pulse_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_count_i == '0) begin
                            // Empty burst completes immediately without a pulse.
                            done_q <= 1'b1;
                        end else begin
                            period_q    <= cmd_period_i;
                            remaining_q <= cmd_count_i;
                            counter_q   <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        // Abort wins over a coincident terminal count.
                        counter_q   <= '0;
                        remaining_q <= '0;
                        aborted_q   <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (ena_i) begin
                        if (period_end) begin
                            counter_q   <= '0;
                            pulse_q     <= 1'b1;
                            remaining_q <= remaining_d;
                            if (last_pulse) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            counter_q <= counter_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o     = pulse_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign busy_o      = busy_q;
    assign remaining_o = remaining_q;
    assign state_o     = state_q;

    // Structural invariants of the counter and strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (counter_q <= period_q)
                else $error("period counter beyond latched period");
            assert (busy_q == (state_q == ST_RUN))
                else $error("busy out of step with state");
            assert (!(pulse_q && aborted_q))
                else $error("pulse and aborted strobes together");
            assert (!((state_q == ST_RUN) && (remaining_q == '0)))
                else $error("running with nothing remaining");
        end
    end

endmodule

// File: tb/tb_pulse_train_controller.sv
// Directed bench for pulse_train_controller. Each test restarts a cycle
// count at 0 (the cycle the command is presented); expected pulse, done and
// aborted cycle numbers are queued by hand and consumed by a monitor.
module tb_pulse_train_controller;

    localparam int PW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [PW-1:0] cmd_period_i;
    logic [CW-1:0] cmd_count_i;
    logic          abort_i;
    logic          pulse_o;
    logic          done_o;
    logic          aborted_o;
    logic          busy_o;
    logic [CW-1:0] remaining_o;
    logic          state_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit ena_toggle = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_rem_q[$];
    logic [31:0] exp_done_q[$];
    logic [31:0] exp_abt_q[$];

    pulse_train_controller #(.PW(PW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena_i        (ena_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_period_i (cmd_period_i),
        .cmd_count_i  (cmd_count_i),
        .abort_i      (abort_i),
        .pulse_o      (pulse_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o),
        .busy_o       (busy_o),
        .remaining_o  (remaining_o),
        .state_o      (state_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every observed strobe must match the next queued cycle.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (pulse_o === 1'b1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hffff_ffff;
            check("pulse_cycle", cyc, e);
            e = (exp_rem_q.size() != 0) ? exp_rem_q.pop_front() : 32'hffff_ffff;
            check("pulse_remaining", 32'(remaining_o), e);
        end
        if (done_o === 1'b1) begin
            e = (exp_done_q.size() != 0) ? exp_done_q.pop_front() : 32'hffff_ffff;
            check("done_cycle", cyc, e);
        end
        if (aborted_o === 1'b1) begin
            e = (exp_abt_q.size() != 0) ? exp_abt_q.pop_front() : 32'hffff_ffff;
            check("aborted_cycle", cyc, e);
        end
        if (busy_o === 1'b1) busy_cnt++;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ena_toggle) ena_i = (cyc % 2 == 0);
    endtask

    task automatic run_until(input int last);
        while (cyc < last) tick();
    endtask

    task automatic start_test();
        cyc = 0;
        busy_cnt = 0;
    endtask

    task automatic present(input int p, input int c);
        cmd_period_i = PW'(p);
        cmd_count_i  = CW'(c);
        cmd_valid_i  = 1'b1;
    endtask

    task automatic end_test(input string tag);
        check({tag, "_pulses_left"}, exp_q.size(), 0);
        check({tag, "_done_left"}, exp_done_q.size(), 0);
        check({tag, "_aborted_left"}, exp_abt_q.size(), 0);
        exp_q.delete();
        exp_rem_q.delete();
        exp_done_q.delete();
        exp_abt_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        ena_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_period_i = '0;
        cmd_count_i = '0;
        abort_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_pulse", pulse_o, 0);
        check("rst_done", done_o, 0);
        check("rst_aborted", aborted_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_remaining", remaining_o, 0);
        check("rst_state", state_o, 0);
        check("rst_ready", cmd_ready_o, 1);
        tick();

        // Basic burst P=3 C=2: pulses 5, 9; done 9; busy 1..8.
        start_test();
        exp_q.push_back(5); exp_rem_q.push_back(1);
        exp_q.push_back(9); exp_rem_q.push_back(0);
        exp_done_q.push_back(9);
        present(3, 2);
        #1 check("t1_ready_c0", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
        #1 check("t1_busy_c1", busy_o, 1);
        check("t1_rem_c1", remaining_o, 2);
        run_until(9);
        check("t1_busy_c9", busy_o, 0);
        check("t1_ready_c9", cmd_ready_o, 1);
        run_until(14);
        check("t1_busy_cycles", busy_cnt, 8);
        end_test("t1");

        // P=0 C=3 then P=1 C=1 held from cycle 1, accepted at 4.
        start_test();
        exp_q.push_back(2); exp_rem_q.push_back(2);
        exp_q.push_back(3); exp_rem_q.push_back(1);
        exp_q.push_back(4); exp_rem_q.push_back(0);
        exp_q.push_back(7); exp_rem_q.push_back(0);
        exp_done_q.push_back(4);
        exp_done_q.push_back(7);
        present(0, 3);
        tick();
        present(1, 1);
        #1 check("t2_ready_c1", cmd_ready_o, 0);
        run_until(4);
        check("t2_ready_c4", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
        #1 check("t2_busy_c5", busy_o, 1);
        run_until(11);
        check("t2_busy_cycles", busy_cnt, 5);
        end_test("t2");

        // C=0: done at 1, no pulse, never busy.
        start_test();
        exp_done_q.push_back(1);
        present(5, 0);
        tick();
        cmd_valid_i = 1'b0;
        #1 check("t3_state_c1", state_o, 0);
        run_until(8);
        check("t3_busy_cycles", busy_cnt, 0);
        end_test("t3");

        // P=1 C=2 with ena alternating 1,0: pulses 5, 9.
        start_test();
        ena_toggle = 1'b1;
        ena_i = 1'b1;
        exp_q.push_back(5); exp_rem_q.push_back(1);
        exp_q.push_back(9); exp_rem_q.push_back(0);
        exp_done_q.push_back(9);
        present(1, 2);
        tick();
        cmd_valid_i = 1'b0;
        run_until(12);
        ena_toggle = 1'b0;
        ena_i = 1'b1;
        check("t4_busy_cycles", busy_cnt, 8);
        end_test("t4");

        // P=4 C=5: pulses 6, 11; abort in 12 -> aborted 13.
        start_test();
        exp_q.push_back(6);  exp_rem_q.push_back(4);
        exp_q.push_back(11); exp_rem_q.push_back(3);
        exp_abt_q.push_back(13);
        present(4, 5);
        tick();
        cmd_valid_i = 1'b0;
        run_until(12);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        #1 check("t5_rem_c13", remaining_o, 0);
        check("t5_busy_c13", busy_o, 0);
        check("t5_ready_c13", cmd_ready_o, 1);
        run_until(25);
        end_test("t5");

        // Abort coincident with the terminal count of P=0 C=1.
        start_test();
        exp_abt_q.push_back(2);
        present(0, 1);
        tick();
        cmd_valid_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        #1 check("t5b_pulse_c2", pulse_o, 0);
        check("t5b_done_c2", done_o, 0);
        check("t5b_rem_c2", remaining_o, 0);
        run_until(6);
        end_test("t5b");

        // Abort in IDLE with a command: no accept, no strobe.
        start_test();
        present(2, 1);
        abort_i = 1'b1;
        #1 check("t6_ready_c0", cmd_ready_o, 0);
        tick();
        cmd_valid_i = 1'b0;
        abort_i = 1'b0;
        #1 check("t6_state_c1", state_o, 0);
        run_until(8);
        check("t6_busy_cycles", busy_cnt, 0);
        end_test("t6");

        // Reset mid-burst at the cycle a pulse would be issued.
        start_test();
        exp_q.push_back(4); exp_rem_q.push_back(3);
        present(2, 4);
        tick();
        cmd_valid_i = 1'b0;
        run_until(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check("t7_pulse_c7", pulse_o, 0);
        check("t7_busy_c7", busy_o, 0);
        check("t7_rem_c7", remaining_o, 0);
        check("t7_state_c7", state_o, 0);
        check("t7_ready_c7", cmd_ready_o, 1);
        run_until(16);
        end_test("t7");

        // Extremes P=255 C=255: pulses 257 + 256k, last at 65281.
        start_test();
        for (int k = 0; k < 255; k++) begin
            exp_q.push_back(32'(257 + 256 * k));
            exp_rem_q.push_back(32'(254 - k));
        end
        exp_done_q.push_back(65281);
        present(255, 255);
        tick();
        cmd_valid_i = 1'b0;
        #1 check("t8_rem_c1", remaining_o, 255);
        run_until(65281);
        check("t8_busy_end", busy_o, 0);
        check("t8_ready_end", cmd_ready_o, 1);
        run_until(65285);
        check("t8_busy_cycles", busy_cnt, 65280);
        end_test("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_train_controller.md
# pulse_train_controller

Sequences finite bursts of periodic one-cycle pulses on behalf of a command source such as a CPU register block or test sequencer. Each accepted command specifies a period and a pulse count. The block runs its internal period counter until the burst completes or is aborted, then reports completion and accepts the next command. It sits between the control plane and any consumer of timed strobes: stepper drivers, sample triggers, LED blinkers.

## Interface
- PW, 8: width of period field and internal period counter.
- CW, 8: width of pulse-count field and remaining counter.

Ports (all outputs registered except cmd_ready):
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  tick enable; period counter advances only on cycles with ena=1.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  combinational; = (state==IDLE) && !abort.
- cmd_period  in  PW  P; pulse spacing is P+1 enabled cycles.
- cmd_count  in  CW  C; number of pulses in burst.
- abort  in  1  cancel running burst.
- pulse  out  1  one-cycle output strobe.
- done  out  1  one-cycle strobe; burst completed normally.
- aborted  out  1  one-cycle strobe; burst cancelled.
- busy  out  1  high while state==RUN.
- remaining  out  CW  pulses still to be issued.

## Operation
- States: IDLE, RUN. Reset: state=IDLE. Reset values: pulse=0, done=0, aborted=0, busy=0, remaining=0, counter=0, latched period=0.
- Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready. The source holds cmd_* stable until accepted.
- Accept with C≠0: latch P, remaining<=C, counter<=0, state->RUN.
- Accept with C=0: stay IDLE, done<=1 next cycle, no pulse.
- RUN, abort=0, ena=1:
  - counter<P: counter+1.
  - counter==P: counter<=0, pulse<=1, remaining<=remaining-1.
  - If remaining==1 at that point: also done<=1, state->IDLE.
- RUN, ena=0: counter, remaining and state hold.
- RUN, abort=1: state->IDLE, counter<=0, remaining<=0, aborted<=1, no pulse, no done.
  - Abort overrides a coincident terminal count: aborted=1, pulse=0, done=0.
- IDLE, abort=1: ignored, no aborted strobe. cmd_ready is low that cycle, so no command is accepted.
- pulse, done and aborted default to 0 every cycle unless set above.
- Arithmetic is unsigned. The counter never exceeds P, so there is no wrap. remaining never underflows because RUN is always left when remaining reaches 0.
- P=2^PW-1 and C=2^CW-1 are legal and must work without overflow.
- rst overrides all inputs, including in mid-burst. After rst deassertion the block is in IDLE with cmd_ready=1, and no strobe is emitted for the interrupted burst.

## Timing
- Command accepted in cycle T, ena held high:
  - busy=1 from T+1.
  - First pulse in cycle T+2+P.
  - Subsequent pulses every P+1 cycles.
  - Final pulse in cycle T+2+P+(C-1)(P+1). done=1, busy=0 and cmd_ready=1 in that same cycle.
- A back-to-back command accepted in the final-pulse cycle produces its first pulse P+2 cycles later.
- remaining shows the post-decrement value in the same cycle as the corresponding pulse.
- C=0: done in cycle T+1, busy never asserted.
- Abort sampled in cycle A: aborted=1 and busy=0 in A+1. cmd_ready=1 in A+1 if abort is low then.
- With ena duty cycle <100%, spacing counts enabled cycles only. pulse still lasts exactly one clk cycle.

## Test plan
- Basic burst: P=3, C=2 accepted cycle 0, ena=1 -> pulse at cycles 5 and 9 only; done at 9; busy cycles 1–8; remaining 2→1 at 5, 0 at 9.
- Minimum period: P=0, C=3 accepted cycle 0 -> pulses at cycles 2, 3, 4; done at 4.
  - Second command (P=1, C=1) held valid from cycle 1 is accepted at cycle 4 -> pulse at 7.
- Zero count and enable gating:
  - C=0 -> done at cycle 1, no pulse, busy stays 0.
  - P=1, C=2 with ena toggling 1,0,1,0… -> pulse spacing 4 clk cycles.
- Abort: P=4, C=5; abort one cycle after the 2nd pulse -> aborted one cycle later, remaining=0, no further pulse, no done.
  - Abort in IDLE coincident with cmd_valid -> command not accepted, no aborted strobe.
- Reset mid-burst and extremes:
  - rst during RUN -> all outputs 0 next cycle, cmd_ready=1 after release.
  - P=255, C=255 -> pulses every 256 cycles, 255 pulses total, then done.
